board_sequencer: RTL
====================

# board_sequencer

Owns the 64-square chess board register file and sequences every change to it. It runs the initial-position load and executes atomic two-step moves requested by game logic. It also provides two registered read ports (display, game logic) plus a flat 256-bit board image. It sits between the game logic FSM and the board storage and is the only writer of the board.

## Interface
Parameters:
- `INIT_ON_RESET`, default 1: when 1, the initial-position load starts automatically after reset release.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `init_req`  in  1  request reload of the initial position (level, sampled each cycle).
- `mv_req`  in  1  move request; hold until `mv_ack`.
- `mv_src`  in  6  source square {row[2:0], col[2:0]}.
- `mv_dst`  in  6  destination square.
- `mv_ack`  out  1  one-cycle pulse; move accepted, `mv_src`/`mv_dst` latched.
- `mv_done`  out  1  one-cycle pulse; board updated for the move.
- `busy`  out  1  high in any state other than IDLE.
- `init_done`  out  1  one-cycle pulse after square 63 is written.
- `rd_addr_a`, `rd_addr_b`  in  6  read addresses (display, logic).
- `rd_data_a`, `rd_data_b`  out  4  registered square contents.
- `board_flat`  out  256  square i at bits [4i+3:4i], combinational from the register file.

## Operation
- Square encoding: {color, type[2:0]}. Color 0 is white, 1 is black. Types: 0 none, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king. Empty square = 4'h0.
- Initial position:
  - Row 7: white R N B Q K B N R, col 0..7.
  - Row 6: white pawns.
  - Rows 5..2: empty.
  - Row 1: black pawns.
  - Row 0: black R N B Q K B N R.
- FSM states and transitions:
  - IDLE: `init_req` has priority over `mv_req`. On `init_req`, go to INIT with counter = 0. Otherwise, on `mv_req`, pulse `mv_ack`, latch src/dst, and go to MV_DST.
  - INIT: write one square per cycle, at address = counter, value from the fixed layout. Counter increments each cycle. After address 63, pulse `init_done` and return to IDLE. Counter wraps 63→0 and is not used again.
  - MV_DST: `board[dst] <= board[src]`, then go to MV_SRC.
  - MV_SRC: `board[src] <= 4'h0`, pulse `mv_done`, go to IDLE.
- Special cases:
  - `src == dst`: both write cycles are suppressed, the board is unchanged, and `mv_ack`/`mv_done` still pulse.
  - `init_req` asserted during a move: the move completes first. Init starts from IDLE if `init_req` is still high.
  - `mv_req` during INIT: not acked until INIT finishes.
- Read ports: `rd_data_x <= board[rd_addr_x]` every cycle, independent of the FSM. A read and a write to the same square in the same cycle return the pre-write value.
- Reset: asynchronous. All 64 squares = 0, state = INIT if `INIT_ON_RESET` else IDLE, counter = 0. `mv_ack`, `mv_done`, `init_done` = 0; `rd_data_a/b` = 0. `busy` reflects state, so it is 1 in reset when `INIT_ON_RESET` = 1. Reset asserted mid-move or mid-init aborts the operation immediately; no partial-move recovery.

## Timing
- Move latency:
  - `mv_ack` in the cycle IDLE sees `mv_req` (cycle 0).
  - Destination written at the edge ending cycle 1.
  - Source cleared and `mv_done` high in cycle 2.
  - Next `mv_ack` is possible in cycle 3.
- Init: 64 write cycles. `init_done` is high in the last write cycle, and `busy` drops the following cycle.
- Read latency: 1 cycle.
- `board_flat` reflects writes one cycle after the write edge.

## Configuration
- `BOARD_SEQ_CAPTURE_EN`, when defined:
  - Adds output `cap_piece[3:0]`, which latches `board[dst]` in MV_DST. It is 0 when the destination was empty or `src == dst`.
  - Adds `cap_cnt_w[3:0]` and `cap_cnt_b[3:0]`, counts of captured white/black pieces. Each increments on a non-empty capture and saturates at 15.
  - All three clear on reset and on entry to INIT.
- When not defined: these ports and registers are absent, and behaviour is otherwise identical.

## Test plan
- Reset release with `INIT_ON_RESET` = 1, then 64 cycles → `init_done` pulses once. The board must match: `board_flat[3:0]` = 4'hC (black rook on sq 0), sq 60 = 4'h6 (white king), sq 28 = 4'h0.
- After init, move src = 52, dst = 36 → `mv_ack` in cycle 0, `mv_done` in cycle 2. Then sq 36 = 4'h1, sq 52 = 4'h0, `busy` low in cycle 3.
- `mv_req` and `init_req` asserted together in IDLE → INIT taken, no `mv_ack` for 64 cycles, then the move is acked.
- Move with src = dst = 12 → ack/done pulse, board unchanged; with `BOARD_SEQ_CAPTURE_EN`, `cap_piece` = 0.
- Capture: place a black pawn on sq 36, then move the white queen (sq 59) to 36 → sq 36 = 4'h5; with the macro, `cap_piece` = 4'h9 and `cap_cnt_b` = 1.
- `Reset_n` low during MV_SRC → all outputs return to reset values immediately and all squares read 0.

Source files
------------

// File: rtl/board_sequencer.sv
// board_sequencer: sole writer of the 64-square board; runs the initial-position load and atomic two-step moves.
// Move ack cycle 0, done cycle 2; init 64 cycles; reads 1 cycle; mv_req is simply not acked while busy. Optional BOARD_SEQ_CAPTURE_EN.
module board_sequencer #(
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic         clk,
   input  logic         Reset_n,
   input  logic         init_req,
   input  logic         mv_req,
   input  logic [5:0]   mv_src,
   input  logic [5:0]   mv_dst,
   output logic         mv_ack,
   output logic         mv_done,
   output logic         busy,
   output logic         init_done,
   input  logic [5:0]   rd_addr_a,
   input  logic [5:0]   rd_addr_b,
   output logic [3:0]   rd_data_a,
   output logic [3:0]   rd_data_b,
   output logic [255:0] board_flat
`ifdef BOARD_SEQ_CAPTURE_EN
   ,
   output logic [3:0]   cap_piece,
   output logic [3:0]   cap_cnt_w,
   output logic [3:0]   cap_cnt_b
`endif
);

   typedef enum logic [1:0] {IDLE, INIT, MV_DST, MV_SRC} state_t;

   localparam state_t RESET_STATE = state_t'(INIT_ON_RESET ? INIT : IDLE);

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [5:0] src_q, dst_q;
   logic [3:0] board_q [64];
   logic       same_sq;
   logic       wr_en;
   logic [5:0] wr_addr;
   logic [3:0] wr_data;

   // Row 0 black back rank, row 1 black pawns, row 6 white pawns, row 7 white back rank.
   function automatic logic [3:0] init_piece(input logic [5:0] sq);
      logic [2:0] back_type;
      case (sq[2:0])
         3'd0, 3'd7: back_type = 3'd4;
         3'd1, 3'd6: back_type = 3'd2;
         3'd2, 3'd5: back_type = 3'd3;
         3'd3:       back_type = 3'd5;
         default:    back_type = 3'd6;
      endcase
      case (sq[5:3])
         3'd0:    init_piece = {1'b1, back_type};
         3'd1:    init_piece = 4'h9;
         3'd6:    init_piece = 4'h1;
         3'd7:    init_piece = {1'b0, back_type};
         default: init_piece = 4'h0;
      endcase
   endfunction

   assign same_sq = (src_q == dst_q);
   assign busy    = (state_q != IDLE);

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= RESET_STATE;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mv_ack    = 1'b0;
      mv_done   = 1'b0;
      init_done = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = cnt_q;
      wr_data   = init_piece(cnt_q);
      case (state_q)
         IDLE: begin
            if (init_req) begin
               state_d = INIT;
               cnt_d   = 6'd0;
            end else if (mv_req) begin
               mv_ack  = 1'b1;
               state_d = MV_DST;
            end
         end
         INIT: begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
               init_done = 1'b1;
               state_d   = IDLE;
            end
         end
         MV_DST: begin
            wr_en   = !same_sq;
            wr_addr = dst_q;
            wr_data = board_q[src_q];
            state_d = MV_SRC;
         end
         MV_SRC: begin
            wr_en   = !same_sq;
            wr_addr = src_q;
            wr_data = 4'h0;
            mv_done = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         src_q <= 6'd0;
         dst_q <= 6'd0;
      end else if (mv_ack) begin
         src_q <= mv_src;
         dst_q <= mv_dst;
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 64; i++) board_q[i] <= 4'h0;
      end else if (wr_en) begin
         board_q[wr_addr] <= wr_data;
      end
   end

   // Read ports sample the array before this edge's write lands.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_data_a <= 4'h0;
         rd_data_b <= 4'h0;
      end else begin
         rd_data_a <= board_q[rd_addr_a];
         rd_data_b <= board_q[rd_addr_b];
      end
   end

   always_comb begin
      board_flat = '0;
      for (int i = 0; i < 64; i++) board_flat[4*i +: 4] = board_q[i];
   end

`ifdef BOARD_SEQ_CAPTURE_EN
   logic [3:0] victim;

   assign victim = same_sq ? 4'h0 : board_q[dst_q];

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cap_piece <= 4'h0;
         cap_cnt_w <= 4'h0;
         cap_cnt_b <= 4'h0;
      end else if (state_q == IDLE && state_d == INIT) begin
         cap_piece <= 4'h0;
         cap_cnt_w <= 4'h0;
         cap_cnt_b <= 4'h0;
      end else if (state_q == MV_DST) begin
         cap_piece <= victim;
         if (victim != 4'h0) begin
            if (victim[3]) begin
               if (cap_cnt_b != 4'hF) cap_cnt_b <= cap_cnt_b + 4'd1;
            end else begin
               if (cap_cnt_w != 4'hF) cap_cnt_w <= cap_cnt_w + 4'd1;
            end
         end
      end
   end
`endif

endmodule
